// File: rtl/am_envelope_gen.sv
// am_envelope_gen
// Runtime-programmable AM envelope generator. A phase accumulator selects a
// point on one of four shapes (triangle, rising saw, square, falling saw);
// the shape is mixed with a programmable depth into an unsigned Q1.(OUT_W-1)
// envelope: env = (FS - d) + d*s/2^(OUT_W-1).
// New step/depth/wave settings arrive over a valid/ready handshake. They are
// held in a shadow copy and swapped into the active set on a phase wrap, so
// one period never mixes two configurations.

module am_envelope_gen #(
    parameter int               ACC_W         = 32,
    parameter int               OUT_W         = 16,
    parameter logic [ACC_W-1:0] STEP_DEFAULT  = ACC_W'(85899),
    parameter logic [OUT_W-1:0] DEPTH_DEFAULT = OUT_W'(16384),
    parameter logic [1:0]       WAVE_DEFAULT  = 2'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [ACC_W-1:0] i_cfg_step,
    input  logic [OUT_W-1:0] i_cfg_depth,
    input  logic [1:0]       i_cfg_wave,
    output logic [OUT_W-1:0] o_env,
    output logic             o_env_valid,
    output logic             o_wrap
);

    // Shape samples are OUT_W-1 bits wide; FS is the largest of them.
    localparam int               SW = OUT_W - 1;
    localparam logic [OUT_W-1:0] FS = {1'b0, {SW{1'b1}}};

    localparam logic [1:0] WAVE_TRI  = 2'd0;
    localparam logic [1:0] WAVE_RSAW = 2'd1;
    localparam logic [1:0] WAVE_SQR  = 2'd2;
    localparam logic [1:0] WAVE_FSAW = 2'd3;

    // IDLE: disabled, configs apply at once. RUN: enabled, nothing pending.
    // ARMED: enabled, shadow waits for the next phase wrap.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    // Depth above full scale would make (FS - d) negative; pin it to FS.
    function automatic logic [OUT_W-1:0] clamp_depth(input logic [OUT_W-1:0] d);
        return (d > FS) ? FS : d;
    endfunction

    // Shape value 0..FS for the current phase and selected waveform.
    function automatic logic [OUT_W-1:0] shape_of(input logic [ACC_W-1:0] acc,
                                                  input logic [1:0]       wave);
        logic [SW-1:0]    tri_v;
        logic [SW-1:0]    saw_v;
        logic [OUT_W-1:0] s;
        tri_v = acc[ACC_W-2 -: SW];
        saw_v = acc[ACC_W-1 -: SW];
        case (wave)
            WAVE_TRI:  s = acc[ACC_W-1] ? {1'b0, ~tri_v} : {1'b0, tri_v};
            WAVE_RSAW: s = {1'b0, saw_v};
            WAVE_SQR:  s = acc[ACC_W-1] ? '0 : FS;
            WAVE_FSAW: s = FS - {1'b0, saw_v};
            default:   s = '0;
        endcase
        return s;
    endfunction

    // Depth mix; with d, s <= FS the sum stays <= FS, so no saturation step.
    function automatic logic [OUT_W-1:0] mix_env(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
        logic [2*OUT_W-1:0] prod;
        prod = {{OUT_W{1'b0}}, d} * {{OUT_W{1'b0}}, s};
        return (FS - d) + prod[SW +: OUT_W];
    endfunction

    // Active configuration, shadow configuration, control state.
    logic [ACC_W-1:0] step_act;
    logic [OUT_W-1:0] depth_act;
    logic [1:0]       wave_act;
    logic [ACC_W-1:0] step_sh;
    logic [OUT_W-1:0] depth_sh;
    logic [1:0]       wave_sh;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             cfg_accept;
    logic             load_sh;
    logic             apply_in;
    logic             apply_sh;

    // Phase accumulator and carry.
    logic [ACC_W-1:0] acc_p0;
    logic [ACC_W:0]   acc_sum;
    logic             wrap_now;
    logic             wrap_p0;

    // Pipeline registers.
    logic [OUT_W-1:0] s_p1;
    logic [OUT_W-1:0] d_p1;
    logic             vld_p1;
    logic             wrap_p1;

    assign o_cfg_ready = (state != ST_ARMED);
    assign cfg_accept  = i_cfg_valid & o_cfg_ready;
    assign acc_sum     = {1'b0, acc_p0} + {1'b0, step_act};
    assign wrap_now    = i_enable & acc_sum[ACC_W];
    assign load_sh     = cfg_accept;

    // Next-state and config-swap decisions.
    always_comb begin
        state_nxt = state;
        apply_in  = 1'b0;
        apply_sh  = 1'b0;
        case (state)
            ST_IDLE: begin
                apply_in = cfg_accept;
                if (i_enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!i_enable) begin
                    apply_in  = cfg_accept;
                    state_nxt = ST_IDLE;
                end else if (cfg_accept) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // An accept in the wrap cycle moved us here after that wrap
                // was evaluated, so only a later wrap releases the shadow.
                if (!i_enable) begin
                    apply_sh  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wrap_now) begin
                    apply_sh  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Shadow capture on every accepted transfer; cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_sh  <= '0;
            depth_sh <= '0;
            wave_sh  <= '0;
        end else if (load_sh) begin
            step_sh  <= i_cfg_step;
            depth_sh <= i_cfg_depth;
            wave_sh  <= i_cfg_wave;
        end
    end

    // Active config: direct load while idle, shadow swap on wrap/disable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_act  <= STEP_DEFAULT;
            depth_act <= DEPTH_DEFAULT;
            wave_act  <= WAVE_DEFAULT;
        end else if (apply_in) begin
            step_act  <= i_cfg_step;
            depth_act <= i_cfg_depth;
            wave_act  <= i_cfg_wave;
        end else if (apply_sh) begin
            step_act  <= step_sh;
            depth_act <= depth_sh;
            wave_act  <= wave_sh;
        end
    end

    // ---- stage p0: phase accumulator, held at 0 while disabled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0  <= '0;
            wrap_p0 <= 1'b0;
        end else if (i_enable) begin
            acc_p0  <= acc_sum[ACC_W-1:0];
            wrap_p0 <= acc_sum[ACC_W];
        end else begin
            acc_p0  <= '0;
            wrap_p0 <= 1'b0;
        end
    end

    // ---- stage p1: shape and clamped depth ----
    always_ff @(posedge clk) begin
        s_p1 <= shape_of(acc_p0, wave_act);
        d_p1 <= clamp_depth(depth_act);
    end

    // Stage p1 control: valid follows the enable of the sampled phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            wrap_p1 <= 1'b0;
        end else begin
            vld_p1  <= i_enable;
            wrap_p1 <= wrap_p0;
        end
    end

    // ---- stage p2: mixed envelope output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_env       <= '0;
            o_env_valid <= 1'b0;
            o_wrap      <= 1'b0;
        end else begin
            o_env       <= mix_env(s_p1, d_p1);
            o_env_valid <= vld_p1;
            o_wrap      <= wrap_p1;
        end
    end

endmodule

// File: tb/tb_am_envelope_gen.sv
// Bench for am_envelope_gen: spot vectors with hand-derived envelope values,
// plus a cycle model feeding a scoreboard for the handshake/wrap sequences.

module tb_am_envelope_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_step;
    logic [15:0] cfg_depth;
    logic [1:0]  cfg_wave;
    logic [15:0] env;
    logic        env_valid;
    logic        wrap;

    am_envelope_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (en),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_step  (cfg_step),
        .i_cfg_depth (cfg_depth),
        .i_cfg_wave  (cfg_wave),
        .o_env       (env),
        .o_env_valid (env_valid),
        .o_wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int env;
        bit wrap;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          use_cfg;
        logic [31:0] step;
        logic [15:0] depth;
        logic [1:0]  wave;
        int          k;
        int          exp;
    } vec_t;
    vec_t vecs[12];

    // Reference model state
    longint m_acc, m_step, m_step_sh;
    int     m_depth, m_wave, m_depth_sh, m_wave_sh;
    int     m_state;
    bit     m_wr;

    int          vcount;
    int          cap_k;
    bit          cap_got;
    logic [15:0] cap_val;
    int          wraps;

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_env(input longint acc, input int depth, input int wave);
        int d, s, t, r;
        d = (depth > 32767) ? 32767 : depth;
        r = int'(acc / 131072);
        t = int'((acc % 64'd2147483648) / 65536);
        case (wave)
            0:       s = (acc >= 64'd2147483648) ? 32767 - t : t;
            1:       s = r;
            2:       s = (acc >= 64'd2147483648) ? 0 : 32767;
            default: s = 32767 - r;
        endcase
        return (32767 - d) + int'((longint'(d) * s) / 32768);
    endfunction

    task automatic model_reset();
        m_acc = 0; m_step = 85899; m_depth = 16384; m_wave = 0;
        m_step_sh = 0; m_depth_sh = 0; m_wave_sh = 0;
        m_state = 0; m_wr = 0;
        sbq.delete();
        vcount = 0;
    endtask

    // One clock cycle: model the cycle, advance, then inspect DUT outputs.
    task automatic tick();
        bit     rdy, acc_ok, n_wr;
        longint sum, n_acc;
        exp_t   e;
        rdy    = (m_state != 2);
        acc_ok = cfg_valid && rdy;
        check("cfg_ready", cfg_ready, rdy);
        if (en) begin
            e.env  = exp_env(m_acc, m_depth, m_wave);
            e.wrap = m_wr;
            sbq.push_back(e);
        end
        sum   = m_acc + m_step;
        n_acc = en ? (sum % 64'd4294967296) : 0;
        n_wr  = en && (sum >= 64'd4294967296);
        if (acc_ok) begin
            m_step_sh = cfg_step; m_depth_sh = cfg_depth; m_wave_sh = cfg_wave;
        end
        case (m_state)
            0: begin
                if (acc_ok) begin m_step = cfg_step; m_depth = cfg_depth; m_wave = cfg_wave; end
                m_state = en ? 1 : 0;
            end
            1: begin
                if (!en) begin
                    if (acc_ok) begin m_step = cfg_step; m_depth = cfg_depth; m_wave = cfg_wave; end
                    m_state = 0;
                end else if (acc_ok) m_state = 2;
            end
            default: begin
                if (!en || n_wr) begin
                    m_step = m_step_sh; m_depth = m_depth_sh; m_wave = m_wave_sh;
                    m_state = en ? 1 : 0;
                end
            end
        endcase
        m_acc = n_acc;
        m_wr  = n_wr;
        @(posedge clk);
        @(negedge clk);
        if (wrap) wraps++;
        if (env_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("env", env, e.env);
                check("wrap", wrap, e.wrap);
                if (vcount == cap_k && !cap_got) begin
                    cap_val = env;
                    cap_got = 1'b1;
                end
                vcount++;
            end
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        en = 1'b0;
        cfg_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_cfg(input logic [31:0] st, input logic [15:0] dp, input logic [1:0] wv);
        cfg_valid = 1'b1;
        cfg_step  = st;
        cfg_depth = dp;
        cfg_wave  = wv;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 32'd0,          16'd0,     2'd0, 0,   16383};
        vecs[1]  = '{1'b1, 32'h0100_0000,  16'd32767, 2'd1, 0,   0};
        vecs[2]  = '{1'b1, 32'h0100_0000,  16'd32767, 2'd1, 128, 16383};
        vecs[3]  = '{1'b1, 32'h0100_0000,  16'd32767, 2'd1, 255, 32639};
        vecs[4]  = '{1'b1, 32'h0100_0000,  16'd16384, 2'd2, 10,  32766};
        vecs[5]  = '{1'b1, 32'h0100_0000,  16'd16384, 2'd2, 200, 16383};
        vecs[6]  = '{1'b1, 32'h0100_0000,  16'd0,     2'd2, 50,  32767};
        vecs[7]  = '{1'b1, 32'h0100_0000,  16'hFFFF,  2'd0, 0,   0};
        vecs[8]  = '{1'b1, 32'h7FFF_0000,  16'hFFFF,  2'd0, 1,   32766};
        vecs[9]  = '{1'b1, 32'h0100_0000,  16'd32767, 2'd3, 128, 16382};
        vecs[10] = '{1'b1, 32'h0100_0000,  16'd32767, 2'd0, 192, 16382};
        vecs[11] = '{1'b1, 32'h0100_0000,  16'd32767, 2'd3, 0,   32766};

        cap_k = -1; cap_got = 1'b0; cap_val = '0; wraps = 0;
        cfg_step = '0; cfg_depth = '0; cfg_wave = '0;
        reset_dut();
        check("rst_env", env, 0);
        check("rst_valid", env_valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_ready", cfg_ready, 1);

        // Spot vectors
        for (int i = 0; i < 12; i++) begin
            reset_dut();
            cap_k = vecs[i].k;
            cap_got = 1'b0;
            if (vecs[i].use_cfg) send_cfg(vecs[i].step, vecs[i].depth, vecs[i].wave);
            en = 1'b1;
            for (int j = 0; j < vecs[i].k + 8 && !cap_got; j++) tick();
            en = 1'b0;
            check($sformatf("vec%0d", i), cap_got ? longint'(cap_val) : -1, vecs[i].exp);
            for (int j = 0; j < 3; j++) tick();
            cap_k = -1;
        end

        // Wrap cadence: one pulse per 256 samples at step 2^24
        reset_dut();
        send_cfg(32'h0100_0000, 16'd32767, 2'd1);
        en = 1'b1;
        wraps = 0;
        for (int j = 0; j < 600; j++) tick();
        check("wrap_count", wraps, 2);

        // Mid-period reconfig: pending until the next wrap
        for (int j = 0; j < 300 && m_acc != 64'h4000_0000; j++) tick();
        send_cfg(32'h0200_0000, 16'd32767, 2'd1);
        check("ready_drop", cfg_ready, 0);
        n = 0;
        while (!cfg_ready && n < 600) begin tick(); n++; end
        check("armed_len_mid", n, 191);
        for (int j = 0; j < 40; j++) tick();

        // Accept coincident with a wrap: old config runs one more period
        reset_dut();
        send_cfg(32'h0100_0000, 16'd32767, 2'd1);
        en = 1'b1;
        for (int j = 0; j < 300 && m_acc != 64'hFF00_0000; j++) tick();
        send_cfg(32'h0080_0000, 16'd16384, 2'd0);
        n = 0;
        while (!cfg_ready && n < 600) begin tick(); n++; end
        check("armed_len_wrap", n, 256);
        for (int j = 0; j < 20; j++) tick();

        // Disable while armed: shadow applied immediately, phase restarts at 0
        send_cfg(32'h0080_0000, 16'd0, 2'd2);
        en = 1'b0;
        tick();
        check("ready_after_disable", cfg_ready, 1);
        for (int j = 0; j < 3; j++) tick();
        en = 1'b1;
        for (int j = 0; j < 20; j++) tick();

        // Zero step: no wraps, so a pending config waits for disable
        reset_dut();
        send_cfg(32'd0, 16'd32767, 2'd1);
        en = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        send_cfg(32'h0100_0000, 16'd32767, 2'd1);
        for (int j = 0; j < 30; j++) tick();
        check("step0_pending", cfg_ready, 0);
        en = 1'b0;
        tick();
        check("step0_applied", cfg_ready, 1);
        en = 1'b1;
        for (int j = 0; j < 20; j++) tick();

        // Async reset while armed, then defaults after release
        send_cfg(32'h0200_0000, 16'd16384, 2'd3);
        tick();
        check("armed_before_reset", cfg_ready, 0);
        check("valid_before_reset", env_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_env", env, 0);
        check("async_valid", env_valid, 0);
        check("async_ready", cfg_ready, 1);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int j = 0; j < 30; j++) tick();

        en = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        check("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
